// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One shift-add or restoring-subtract step per clock; sign fixed once at the end.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_ma;
    logic [XLEN-1:0]   r_mb;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_neg;
    logic              r_neg_rem;
    logic              r_spec;
    logic [XLEN-1:0]   r_spec_res;
    logic [XLEN-1:0]   r_result;
    logic              r_done;

    logic              w_is_div;
    logic              w_sa_en;
    logic              w_sb_en;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_spec_res;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_sel;
    logic [XLEN-1:0]   w_fin;

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign result = r_result;

    // Operand signedness, magnitudes and special divide detection
    always_comb begin
        w_is_div = r_f3[2];
        w_sa_en  = (r_f3 == 3'b001) || (r_f3 == 3'b010) ||
                   (r_f3 == 3'b100) || (r_f3 == 3'b110);
        w_sb_en  = (r_f3 == 3'b001) || (r_f3 == 3'b100) ||
                   (r_f3 == 3'b110);
        w_a_neg  = w_sa_en & r_a[XLEN-1];
        w_b_neg  = w_sb_en & r_b[XLEN-1];
        w_abs_a  = w_a_neg ? (~r_a + 1'b1) : r_a;
        w_abs_b  = w_b_neg ? (~r_b + 1'b1) : r_b;
        w_div0   = w_is_div & (r_b == '0);
        w_ovf    = w_is_div & ~r_f3[0] & (r_a == MIN_NEG) &
                   (r_b == {XLEN{1'b1}});
        w_spec_res = '0;
        if (w_div0)
            w_spec_res = r_f3[1] ? r_a : {XLEN{1'b1}};
        else if (w_ovf)
            w_spec_res = r_f3[1] ? '0 : r_a;
    end

    // One iteration step: shift-add for multiply, trial subtract for divide
    always_comb begin
        w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_ma : '0)};
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_mb};
    end

    // Final sign fix and output word selection
    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
        w_quo    = r_neg ? (~r_lo + 1'b1) : r_lo;
        w_rem    = r_neg_rem ? (~r_hi + 1'b1) : r_hi;
        w_sel    = '0;
        unique case (r_f3)
            3'b000:                 w_sel = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_sel = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_sel = w_quo;
            default:                w_sel = w_rem;
        endcase
        w_fin = r_spec ? r_spec_res : w_sel;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_PREP;
            S_PREP: w_next = (w_div0 | w_ovf) ? S_FIN : S_RUN;
            S_RUN:  if (r_cnt == LAST) w_next = S_FIN;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush)
            w_next = S_IDLE;
    end

    // Datapath: operand latch, setup, iteration and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_f3       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_ma       <= '0;
            r_mb       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg      <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_f3 <= funct3;
                        r_a  <= a;
                        r_b  <= b;
                    end
                end
                S_PREP: begin
                    r_ma       <= w_abs_a;
                    r_mb       <= w_abs_b;
                    r_hi       <= '0;
                    r_lo       <= w_is_div ? w_abs_a : w_abs_b;
                    r_cnt      <= '0;
                    r_neg      <= w_a_neg ^ w_b_neg;
                    r_neg_rem  <= w_a_neg;
                    r_spec     <= w_div0 | w_ovf;
                    r_spec_res <= w_spec_res;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_is_div) begin
                        if (!w_diff[XLEN]) begin
                            r_hi <= w_diff[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= w_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_sum[XLEN:1];
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                end
                S_FIN: begin
                    if (!flush) begin
                        r_result <= w_fin;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Each task drives one scenario and checks its own expected values.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_fail = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Launch one op and wait (bounded) for done; lat counts edges after the start edge
    task automatic run_op(input logic [2:0] f, input logic [31:0] av,
                          input logic [31:0] bv, output logic [31:0] res,
                          output int lat, output int bc);
        @(negedge clk);
        start = 1'b1; funct3 = f; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        bc = busy ? 1 : 0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy) bc++;
        end
        res = result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat; int bc;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, bc);
        n_cmp++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_res got %h want ffffffeb", r); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL mul_lat got %0d want 34", lat); end
        n_cmp++; if (bc !== 34) begin n_fail++; $display("FAIL mul_busy got %0d want 34", bc); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_end got %b want 0", busy); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_pulse got %b want 0", done); end
        n_cmp++; if (result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_hold got %h want ffffffeb", result); end
    endtask

    task automatic test_mulh();
        logic [31:0] r; int lat; int bc;
        run_op(3'b001, 32'h80000000, 32'h80000000, r, lat, bc);
        n_cmp++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL mulh got %h want 40000000", r); end
        run_op(3'b011, 32'h80000000, 32'h80000000, r, lat, bc);
        n_cmp++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL mulhu got %h want 40000000", r); end
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, r, lat, bc);
        n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu got %h want ffffffff", r); end
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
        n_cmp++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_max got %h want fffffffe", r); end
        run_op(3'b001, 32'hFFFFFFFF, 32'h00000003, r, lat, bc);
        n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulh_neg got %h want ffffffff", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat; int bc;
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, r, lat, bc);
        n_cmp++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div got %h want fffffffd", r); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL div_lat got %0d want 34", lat); end
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, r, lat, bc);
        n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem got %h want ffffffff", r); end
        run_op(3'b101, 32'd100, 32'd7, r, lat, bc);
        n_cmp++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu got %h want e", r); end
        run_op(3'b111, 32'd100, 32'd7, r, lat, bc);
        n_cmp++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu got %h want 2", r); end
        run_op(3'b110, 32'd7, 32'hFFFFFFFE, r, lat, bc);
        n_cmp++; if (r !== 32'd1) begin n_fail++; $display("FAIL rem_posdiv got %h want 1", r); end
    endtask

    task automatic test_special();
        logic [31:0] r; int lat; int bc;
        run_op(3'b101, 32'h1234, 32'd0, r, lat, bc);
        n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0 got %h want ffffffff", r); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL divu0_lat got %0d want 2", lat); end
        run_op(3'b111, 32'h1234, 32'd0, r, lat, bc);
        n_cmp++; if (r !== 32'h1234) begin n_fail++; $display("FAIL remu0 got %h want 1234", r); end
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
        n_cmp++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf got %h want 80000000", r); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL div_ovf_lat got %0d want 2", lat); end
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem_ovf got %h want 0", r); end
        run_op(3'b100, 32'hFFFFFFF9, 32'd0, r, lat, bc);
        n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_neg got %h want ffffffff", r); end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat; int bc; int seen;
        run_op(3'b101, 32'd100, 32'd7, r, lat, bc);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flush_quiet got %0d want 0", seen); end
        n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result got %h want e", result); end
        run_op(3'b000, 32'd3, 32'd5, r, lat, bc);
        n_cmp++; if (r !== 32'd15) begin n_fail++; $display("FAIL flush_mul got %h want f", r); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL flush_mul_lat got %0d want 34", lat); end
    endtask

    task automatic test_back_to_back();
        int lat; int got_done;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; got_done = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd100;
            end
            if (lat == 6) start = 1'b0;
            if (done) begin got_done = 1; break; end
        end
        n_cmp++; if (result !== 32'd42) begin n_fail++; $display("FAIL ignore_res got %h want 2a", result); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL ignore_lat got %0d want 34", lat); end
        start = 1'b1; funct3 = 3'b011; a = 32'h80000000; b = 32'h80000000;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", busy); end
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        n_cmp++; if (result !== 32'h40000000) begin n_fail++; $display("FAIL b2b_res got %h want 40000000", result); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_lat got %0d want 34", lat); end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; a = 32'd1000; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_result got %h want 0", result); end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_no_emit got %h want 0", result); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
